ysyx_24090003_wbu: RTL and testbench
====================================

YSYX_24090003_WBU -- requirements
Module: ysyx_24090003_wbu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the PC value loaded at reset.
REQ-002 SHALL have port cpu_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst_n, input, 1, the synchronous active-low reset, sampled on the rising edge of cpu_clk.
REQ-004 SHALL have port in_valid, input, 1, execute-stage result valid.
REQ-005 SHALL have port in_ready, output, 1, write-back stage accepts a result.
REQ-006 SHALL have port in_rd, input, 5, destination GPR index.
REQ-007 SHALL have port in_reg_wdata, input, 32, GPR write data.
REQ-008 SHALL have port in_reg_we, input, 1, GPR write request.
REQ-009 SHALL have port in_mem_addr, input, 32, store address.
REQ-010 SHALL have port in_mem_wdata, input, 32, store data.
REQ-011 SHALL have port in_mem_we, input, 1, store request.
REQ-012 SHALL have port in_npc, input, 32, redirect target.
REQ-013 SHALL have port in_npc_we, input, 1, redirect request.
REQ-014 SHALL have ports rs1_addr and rs2_addr, input, 5 each, GPR read indices.
REQ-015 SHALL have ports rs1_data and rs2_data, output, 32 each, GPR read data.
REQ-016 SHALL have port mem_req_valid, output, 1, store request to data memory.
REQ-017 SHALL have port mem_req_ready, input, 1, data memory accepts the store.
REQ-018 SHALL have ports mem_req_addr and mem_req_wdata, output, 32 each, store address and data.
REQ-019 SHALL have port pc, output, 32, architectural PC.
REQ-020 SHALL have port commit_valid, output, 1, one-cycle pulse per retired instruction.
REQ-021 SHALL have port retire_cnt, output, 32, count of retired instructions.

Function
REQ-022 SHALL contain a 32x32 GPR file with combinational reads; index 0 SHALL always read 0, and writes to index 0 SHALL be ignored.
REQ-023 SHALL NOT bypass same-cycle writes: a read of a register written on the same edge SHALL return the old value.
REQ-024 SHALL implement FSM states IDLE and MEM_WAIT.
REQ-025 SHALL drive in_ready = 1 only in IDLE.
REQ-026 In IDLE with in_valid=1 and in_mem_we=0, SHALL commit on that edge: GPR[in_rd] <= in_reg_wdata if in_reg_we; pc <= in_npc if in_npc_we, else pc+4 (mod 2^32); stay in IDLE.
REQ-027 In IDLE with in_valid=1 and in_mem_we=1, SHALL latch rd, reg_wdata, reg_we, npc, npc_we, mem_addr and mem_wdata, then go to MEM_WAIT.
REQ-028 In MEM_WAIT, SHALL hold mem_req_valid=1 with mem_req_addr and mem_req_wdata stable from the latched values until mem_req_ready=1.
REQ-029 On the MEM_WAIT edge with mem_req_ready=1, SHALL commit the latched GPR write and PC update per REQ-026, drop mem_req_valid on the next cycle, and return to IDLE.
REQ-030 SHALL hold mem_req_valid=0 outside MEM_WAIT.
REQ-031 SHALL ignore in_mem_we, in_reg_we and in_npc_we when in_valid=0; no state SHALL change.
REQ-032 SHALL register commit_valid: high for exactly one cycle after each commit edge, otherwise 0.
REQ-033 SHALL increment retire_cnt by 1 on each commit edge, wrapping 32'hFFFF_FFFF to 0.
REQ-034 SHALL give a store latency of at least 2 cycles from acceptance to commit_valid; a non-store SHALL take 1 cycle.
REQ-035 SHALL accept back-to-back non-store results, one per cycle.

Reset
REQ-036 While cpu_rst_n=0 at an edge, SHALL set pc=RESET_PC, all GPRs=0, state=IDLE, mem_req_valid=0, commit_valid=0, retire_cnt=0, and mem_req_addr and mem_req_wdata=0.
REQ-037 A reset asserted in MEM_WAIT SHALL discard the latched store with no commit, even if mem_req_ready=1 on the same edge.

Verification
REQ-038 Reset scenario: reset -> pc=32'h8000_0000, rs1_data=0 for every rs1_addr, retire_cnt=0.
REQ-039 Write scenario: in_valid=1, rd=5, wdata=32'h1234_5678, reg_we=1 -> next cycle rs1_addr=5 reads 32'h1234_5678, pc=32'h8000_0004, commit_valid pulses once.
REQ-040 x0 scenario: rd=0, wdata=32'hFFFF_FFFF, reg_we=1 -> rs1_addr=0 reads 0, pc advances by 4.
REQ-041 Store scenario: in_mem_we=1, addr=32'h8000_1000, data=32'hDEAD_BEEF, reg_we=0, mem_req_ready held low for 3 cycles -> mem_req_valid high with stable addr/data and in_ready=0; after mem_req_ready=1 -> commit_valid pulses once, mem_req_valid drops.
REQ-042 Redirect scenario: in_npc_we=1, in_npc=32'h8000_0100 -> pc=32'h8000_0100; then a non-redirect result -> pc=32'h8000_0104.
REQ-043 Reset-in-MEM_WAIT scenario: store pending, then cpu_rst_n=0 with mem_req_ready=1 -> no commit_valid, pc=RESET_PC, mem_req_valid=0.

Source files
------------

// File: rtl/ysyx_24090003_wbu.sv
// Write-back unit.
//   Retires execute-stage results: updates the 32x32 GPR file, advances or
//   redirects the PC, and issues stores to data memory before retiring them.
// Ports:
//   cpu_clk, cpu_rst_n        clock, synchronous active-low reset
//   in_valid/in_ready         result handshake from execute
//   in_rd/in_reg_wdata/in_reg_we, in_mem_addr/in_mem_wdata/in_mem_we,
//   in_npc/in_npc_we          result payload
//   rs1_addr/rs2_addr -> rs1_data/rs2_data   combinational GPR reads
//   mem_req_valid/ready, mem_req_addr/wdata  store request to data memory
//   pc, commit_valid, retire_cnt             architectural state / retire info
module ysyx_24090003_wbu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_reg_wdata,
  input  logic        in_reg_we,
  input  logic [31:0] in_mem_addr,
  input  logic [31:0] in_mem_wdata,
  input  logic        in_mem_we,
  input  logic [31:0] in_npc,
  input  logic        in_npc_we,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [31:0] pc,
  output logic        commit_valid,
  output logic [31:0] retire_cnt
);

  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t      state;
  logic [31:0] gpr [32];

  // Store-side copy of the retire payload, held while the store is pending.
  logic [4:0]  l_rd;
  logic [31:0] l_wdata;
  logic        l_we;
  logic [31:0] l_npc;
  logic        l_npc_we;

  logic        commit_now;
  logic [4:0]  c_rd;
  logic [31:0] c_wdata;
  logic        c_we;
  logic [31:0] c_npc;
  logic        c_npc_we;

  assign in_ready = (state == IDLE);

  // Index 0 is hardwired; no bypass, so a same-edge write shows up next cycle.
  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : gpr[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : gpr[rs2_addr];

  // Retire either a non-store straight from the input or the pending store
  // once memory takes it.
  always_comb begin
    commit_now = 1'b0;
    c_rd       = in_rd;
    c_wdata    = in_reg_wdata;
    c_we       = in_reg_we;
    c_npc      = in_npc;
    c_npc_we   = in_npc_we;
    if (state == IDLE) begin
      commit_now = in_valid && !in_mem_we;
    end else begin
      commit_now = mem_req_ready;
      c_rd       = l_rd;
      c_wdata    = l_wdata;
      c_we       = l_we;
      c_npc      = l_npc;
      c_npc_we   = l_npc_we;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if (commit_now && c_we && (c_rd != 5'd0)) begin
      gpr[c_rd] <= c_wdata;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      commit_valid  <= 1'b0;
      retire_cnt    <= 32'd0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      l_rd          <= 5'd0;
      l_wdata       <= 32'd0;
      l_we          <= 1'b0;
      l_npc         <= 32'd0;
      l_npc_we      <= 1'b0;
    end else begin
      commit_valid <= commit_now;
      if (commit_now) begin
        retire_cnt <= retire_cnt + 32'd1;
        pc         <= c_npc_we ? c_npc : pc + 32'd4;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_mem_we) begin
            state         <= MEM_WAIT;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= in_mem_addr;
            mem_req_wdata <= in_mem_wdata;
            l_rd          <= in_rd;
            l_wdata       <= in_reg_wdata;
            l_we          <= in_reg_we;
            l_npc         <= in_npc;
            l_npc_we      <= in_npc_we;
          end
        end
        MEM_WAIT: begin
          if (mem_req_ready) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Scoreboard bench for ysyx_24090003_wbu: the driver updates a plain
// architectural model on each accepted result and queues the expected
// retire record / store; a negedge monitor pops and compares.
module tb_ysyx_24090003_wbu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_reg_wdata = '0;
  logic        in_reg_we = 1'b0;
  logic [31:0] in_mem_addr = '0;
  logic [31:0] in_mem_wdata = '0;
  logic        in_mem_we = 1'b0;
  logic [31:0] in_npc = '0;
  logic        in_npc_we = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [31:0] pc;
  logic        commit_valid;
  logic [31:0] retire_cnt;

  ysyx_24090003_wbu #(.RESET_PC(RST_PC)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_reg_wdata(in_reg_wdata), .in_reg_we(in_reg_we),
    .in_mem_addr(in_mem_addr), .in_mem_wdata(in_mem_wdata), .in_mem_we(in_mem_we),
    .in_npc(in_npc), .in_npc_we(in_npc_we),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .pc(pc), .commit_valid(commit_valid), .retire_cnt(retire_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] stq[$];

  // Architectural reference model
  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          rdy_pct = 50;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_pc  = RST_PC;
    m_cnt = 32'd0;
    expq.delete();
    stq.delete();
  endtask

  // Present one result, wait for acceptance, update the model at acceptance.
  task automatic issue(input logic [4:0] rd, input logic [31:0] wd, input logic rwe,
                       input logic [31:0] maddr, input logic [31:0] mwd, input logic mwe,
                       input logic [31:0] npc, input logic npcwe);
    exp_t e;
    int   budget;
    in_valid = 1'b1; in_rd = rd; in_reg_wdata = wd; in_reg_we = rwe;
    in_mem_addr = maddr; in_mem_wdata = mwd; in_mem_we = mwe;
    in_npc = npc; in_npc_we = npcwe;
    budget = 0;
    while (!in_ready && budget < 200) begin
      mem_req_ready = ($urandom_range(99) < rdy_pct);
      @(posedge cpu_clk); #1;
      budget++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end
    if (rwe && rd != 5'd0) m_gpr[rd] = wd;
    m_pc  = npcwe ? npc : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    e.pc = m_pc; e.cnt = m_cnt; e.rd = rd; e.val = m_gpr[rd];
    expq.push_back(e);
    if (mwe) stq.push_back({maddr, mwd});
    @(posedge cpu_clk); #1;
    in_valid = 1'b0;
    mem_req_ready = ($urandom_range(99) < rdy_pct);
  endtask

  // Idle cycles with junk control flags that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_mem_we = 1'($urandom); in_reg_we = 1'($urandom); in_npc_we = 1'($urandom);
      in_rd = 5'($urandom); in_reg_wdata = $urandom;
      mem_req_ready = ($urandom_range(99) < rdy_pct);
      @(posedge cpu_clk); #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    mem_req_ready = 1'b1;
    while ((expq.size() != 0 || mem_req_valid) && budget < 100) begin
      @(posedge cpu_clk); #1;
      budget++;
    end
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d retires outstanding, required 0", expq.size());
    end
    mem_req_ready = 1'b0;
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      issue(5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
            ($urandom_range(2) == 0), $urandom, ($urandom_range(3) == 0));
      if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
    end
  endtask

  // Monitor
  exp_t mon_e;
  always @(negedge cpu_clk) begin
    if (cpu_rst_n) begin
      if (mem_req_valid) begin
        if (stq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL store_unexpected: mem_req_valid=1 addr %h, required no request", mem_req_addr);
        end else begin
          chk("mem_req_addr", mem_req_addr, stq[0][63:32]);
          chk("mem_req_wdata", mem_req_wdata, stq[0][31:0]);
          chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
          if (mem_req_ready) void'(stq.pop_front());
        end
      end
      if (commit_valid) begin
        if (expq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL commit_unexpected: commit_valid=1, required 0");
        end else begin
          mon_e = expq.pop_front();
          chk("pc", pc, mon_e.pc);
          chk("retire_cnt", retire_cnt, mon_e.cnt);
          rs2_addr = mon_e.rd;
          #1;
          chk("gpr_rd", rs2_data, mon_e.val);
        end
      end
    end
  end

  initial begin
    model_reset();
    cpu_rst_n = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #0.1;
      chk("rst_gpr", rs1_data, 32'd0);
    end
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Plain register write
    rdy_pct = 100;
    issue(5'd5, 32'h1234_5678, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    rs1_addr = 5'd5; #0.1;
    chk("wr_rs1", rs1_data, 32'h1234_5678);
    chk("wr_pc", pc, 32'h8000_0004);

    // x0 write ignored
    issue(5'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    rs1_addr = 5'd0; #0.1;
    chk("x0_rs1", rs1_data, 32'd0);
    chk("x0_pc", pc, 32'h8000_0008);

    // Store with memory stalled for 3 cycles
    rdy_pct = 0;
    issue(5'd0, 32'd0, 1'b0, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("st_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("st_addr", mem_req_addr, 32'h8000_1000);
      chk("st_data", mem_req_wdata, 32'hDEAD_BEEF);
      chk("st_in_ready", {31'd0, in_ready}, 32'd0);
      chk("st_no_commit", {31'd0, commit_valid}, 32'd0);
      mem_req_ready = 1'b0;
      @(posedge cpu_clk); #1;
    end
    mem_req_ready = 1'b1;
    @(posedge cpu_clk); #1;
    mem_req_ready = 1'b0;
    chk("st_commit", {31'd0, commit_valid}, 32'd1);
    chk("st_valid_drop", {31'd0, mem_req_valid}, 32'd0);
    chk("st_pc", pc, 32'h8000_000C);
    @(posedge cpu_clk); #1;
    chk("st_commit_once", {31'd0, commit_valid}, 32'd0);

    // Redirect then fall-through
    rdy_pct = 100;
    issue(5'd3, 32'h0000_0033, 1'b1, 32'd0, 32'd0, 1'b0, 32'h8000_0100, 1'b1);
    chk("redir_pc", pc, 32'h8000_0100);
    issue(5'd4, 32'h0000_0044, 1'b1, 32'd0, 32'd0, 1'b0, 32'h1111_1111, 1'b0);
    chk("redir_next_pc", pc, 32'h8000_0104);

    // Back-to-back non-stores: one per cycle
    for (int i = 0; i < 4; i++)
      issue(5'(i + 8), $urandom, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(2);

    // Randomized mix
    rdy_pct = 50;
    rand_ops(250);
    drain();

    // Reset while a store is pending, memory ready on the same edge
    rdy_pct = 0;
    issue(5'd7, 32'hCAFE_F00D, 1'b1, 32'h8000_2000, 32'h5555_AAAA, 1'b1, 32'd0, 1'b0);
    chk("rmw_pending", {31'd0, mem_req_valid}, 32'd1);
    cpu_rst_n = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge cpu_clk); #1;
    model_reset();
    chk("rmw_no_commit", {31'd0, commit_valid}, 32'd0);
    chk("rmw_pc", pc, RST_PC);
    chk("rmw_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rmw_retire_cnt", retire_cnt, 32'd0);
    rs1_addr = 5'd7; #0.1;
    chk("rmw_gpr7", rs1_data, 32'd0);
    mem_req_ready = 1'b0;
    cpu_rst_n = 1'b1;
    @(posedge cpu_clk); #1;
    chk("rmw_no_commit_after", {31'd0, commit_valid}, 32'd0);
    chk("rmw_pc_hold", pc, RST_PC);

    rdy_pct = 60;
    rand_ops(60);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
